s2c_stream_drv: RTL and testbench

Synthesizable driver directly downstream of the sim-to-C call interface. The testbench calls the C side, then loads the returned packet into this block: a return code plus `DATA_SIZE` 32-bit words. The block buffers the packet and replays it word-by-word on a valid/ready stream into the DUT. It then pulses a request for the next call, and latches end-of-stimulus and error conditions signalled by the return code.

---
 rtl/s2c_stream_drv.sv | 188 ++++++++++++++++++
 tb/tb_s2c_stream_drv.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/s2c_stream_drv.sv
// s2c_stream_drv: buffers one packet returned from the C side (return code plus
// DATA_SIZE words) and replays it word-by-word on a valid/ready stream. When the
// packet is consumed it pulses req_next. End-of-stimulus and error conditions
// from the return code are latched into sticky flags.
module s2c_stream_drv #(
    parameter int DATA_SIZE = 8,
    parameter int DW        = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pkt_load,
    input  logic [31:0]               pkt_ret,
    input  logic [DATA_SIZE*DW-1:0]   pkt_data,
    output logic                      pkt_ready,
    output logic                      req_next,
    output logic                      m_valid,
    output logic [DW-1:0]             m_data,
    output logic                      m_last,
    input  logic                      m_ready,
    output logic                      end_flag,
    output logic                      err_flag,
    output logic [31:0]               word_cnt
);

    // Index width; a single-word packet still needs one bit of index.
    localparam int IW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_END    = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;

    logic [DW-1:0]   pkt_buf_r [DATA_SIZE];
    logic [IW-1:0]   idx_r;
    logic [IW-1:0]   idx_s;
    logic [IW-1:0]   last_idx_r;
    logic [IW-1:0]   last_idx_s;
    logic [IW-1:0]   idx_inc_s;
    logic            load_buf_s;

    logic            m_valid_s;
    logic [DW-1:0]   m_data_s;
    logic            m_last_s;
    logic            req_next_s;
    logic            end_flag_s;
    logic            err_flag_s;
    logic [31:0]     word_cnt_s;

    logic            ret_zero_s;
    logic            ret_bad_s;
    logic            handshake_s;

    // Return-code decode: negative values are also huge when viewed unsigned,
    // but the sign bit is tested explicitly to keep the intent obvious.
    assign ret_zero_s  = (pkt_ret == 32'd0);
    assign ret_bad_s   = pkt_ret[31] | (pkt_ret > 32'(DATA_SIZE));
    assign handshake_s = m_valid & m_ready;
    assign idx_inc_s   = idx_r + IW'(1);

    // pkt_ready is the only output decoded directly from state.
    assign pkt_ready = (state_r == ST_IDLE);

    // Next-state and next-output decode for the packet driver.
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        last_idx_s = last_idx_r;
        load_buf_s = 1'b0;
        m_valid_s  = m_valid;
        m_data_s   = m_data;
        m_last_s   = m_last;
        req_next_s = 1'b0;
        end_flag_s = end_flag;
        err_flag_s = err_flag;
        word_cnt_s = word_cnt;

        case (state_r)
            ST_IDLE: begin
                if (pkt_load) begin
                    if (ret_zero_s) begin
                        end_flag_s = 1'b1;
                        state_s    = ST_END;
                    end else if (ret_bad_s) begin
                        // Discard the packet but let the caller move on.
                        err_flag_s = 1'b1;
                        req_next_s = 1'b1;
                    end else begin
                        // Word 0 is presented straight from the input so it
                        // appears the cycle after the load.
                        load_buf_s = 1'b1;
                        idx_s      = {IW{1'b0}};
                        last_idx_s = pkt_ret[IW-1:0] - IW'(1);
                        m_valid_s  = 1'b1;
                        m_data_s   = pkt_data[DW-1:0];
                        m_last_s   = (pkt_ret == 32'd1);
                        state_s    = ST_STREAM;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_STREAM: begin
                if (pkt_load) begin
                    err_flag_s = 1'b1;
                end else begin
                    err_flag_s = err_flag;
                end

                if (handshake_s) begin
                    word_cnt_s = word_cnt + 32'd1;
                    if (m_last) begin
                        m_valid_s  = 1'b0;
                        m_last_s   = 1'b0;
                        req_next_s = 1'b1;
                        state_s    = ST_IDLE;
                    end else begin
                        idx_s    = idx_inc_s;
                        m_data_s = pkt_buf_r[idx_inc_s];
                        m_last_s = (idx_inc_s == last_idx_r);
                    end
                end else begin
                    state_s = ST_STREAM;
                end
            end

            ST_END: begin
                state_s = ST_END;
            end

            default: begin
                m_valid_s = 1'b0;
                m_last_s  = 1'b0;
                state_s   = ST_IDLE;
            end
        endcase
    end

    // State, index and registered stream/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            idx_r      <= {IW{1'b0}};
            last_idx_r <= {IW{1'b0}};
            m_valid    <= 1'b0;
            m_data     <= {DW{1'b0}};
            m_last     <= 1'b0;
            req_next   <= 1'b0;
            end_flag   <= 1'b0;
            err_flag   <= 1'b0;
            word_cnt   <= 32'd0;
        end else begin
            state_r    <= state_s;
            idx_r      <= idx_s;
            last_idx_r <= last_idx_s;
            m_valid    <= m_valid_s;
            m_data     <= m_data_s;
            m_last     <= m_last_s;
            req_next   <= req_next_s;
            end_flag   <= end_flag_s;
            err_flag   <= err_flag_s;
            word_cnt   <= word_cnt_s;
        end
    end

    // Packet buffer: captures every word on an accepted load; words past len
    // are stored but never presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DATA_SIZE; i++) begin
                pkt_buf_r[i] <= {DW{1'b0}};
            end
        end else if (load_buf_s) begin
            for (int i = 0; i < DATA_SIZE; i++) begin
                pkt_buf_r[i] <= pkt_data[DW*i +: DW];
            end
        end else begin
            for (int i = 0; i < DATA_SIZE; i++) begin
                pkt_buf_r[i] <= pkt_buf_r[i];
            end
        end
    end

endmodule

// File: tb/tb_s2c_stream_drv.sv
// Directed bench for s2c_stream_drv: hand-computed vectors per scenario.
module tb_s2c_stream_drv;

    localparam int DS = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              pkt_load;
    logic [31:0]       pkt_ret;
    logic [DS*32-1:0]  pkt_data;
    logic              pkt_ready;
    logic              req_next;
    logic              m_valid;
    logic [31:0]       m_data;
    logic              m_last;
    logic              m_ready;
    logic              end_flag;
    logic              err_flag;
    logic [31:0]       word_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    s2c_stream_drv #(.DATA_SIZE(DS), .DW(32)) dut (
        .clk(clk), .rst(rst), .pkt_load(pkt_load), .pkt_ret(pkt_ret),
        .pkt_data(pkt_data), .pkt_ready(pkt_ready), .req_next(req_next),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .end_flag(end_flag), .err_flag(err_flag), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Fill pkt_data with base+i in word i.
    task automatic set_pkt(input logic [31:0] ret, input logic [31:0] base);
        pkt_ret = ret;
        for (int i = 0; i < DS; i++) pkt_data[32*i +: 32] = base + 32'(i);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // Status bundle order: {pkt_ready, m_valid, m_last, req_next, end_flag, err_flag}
    task automatic test_reset();
        rst = 1'b1; pkt_load = 1'b0; pkt_ret = 32'd0; pkt_data = '0; m_ready = 1'b0;
        cyc(); cyc();
        vec_cnt++;
        if ({pkt_ready, m_valid, m_last, req_next, end_flag, err_flag} !== 6'b100000) begin
            err_cnt++; $display("FAIL reset_status got %b exp 100000", {pkt_ready, m_valid, m_last, req_next, end_flag, err_flag});
        end
        vec_cnt++;
        if ({m_data, word_cnt} !== 64'd0) begin
            err_cnt++; $display("FAIL reset_data_cnt got %h/%h exp 0/0", m_data, word_cnt);
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_basic();
        m_ready = 1'b1;
        set_pkt(32'd3, 32'hA000_0000);
        pkt_load = 1'b1;
        cyc();
        pkt_load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            vec_cnt++;
            if ({m_valid, m_last, pkt_ready} !== {1'b1, (k == 2), 1'b0} || m_data !== 32'hA000_0000 + 32'(k)) begin
                err_cnt++; $display("FAIL basic_word%0d got v%b l%b r%b %h exp v1 l%b r0 %h", k, m_valid, m_last, pkt_ready, m_data, (k == 2), 32'hA000_0000 + 32'(k));
            end
            cyc();
        end
        vec_cnt++;
        if ({req_next, m_valid, pkt_ready} !== 3'b101 || word_cnt !== 32'd3) begin
            err_cnt++; $display("FAIL basic_done got req%b v%b r%b cnt%0d exp req1 v0 r1 cnt3", req_next, m_valid, pkt_ready, word_cnt);
        end
        cyc();
        vec_cnt++;
        if (req_next !== 1'b0) begin
            err_cnt++; $display("FAIL basic_req_pulse got %b exp 0", req_next);
        end
    endtask

    task automatic test_stall();
        int k = 0;
        int c = 0;
        m_ready = 1'b1;
        set_pkt(32'd8, 32'hB000_0010);
        pkt_load = 1'b1;
        cyc();
        pkt_load = 1'b0;
        while (k < 8 && c < 40) begin
            m_ready = (c % 2 == 0);
            vec_cnt++;
            if ({m_valid, m_last} !== {1'b1, (k == 7)} || m_data !== 32'hB000_0010 + 32'(k)) begin
                err_cnt++; $display("FAIL stall_c%0d got v%b l%b %h exp v1 l%b %h", c, m_valid, m_last, m_data, (k == 7), 32'hB000_0010 + 32'(k));
            end
            cyc();
            if (m_ready) k++;
            c++;
        end
        vec_cnt++;
        if (k != 8) begin
            err_cnt++; $display("FAIL stall_timeout got %0d words exp 8", k);
        end
        vec_cnt++;
        if ({req_next, m_valid, err_flag} !== 3'b100 || word_cnt !== 32'd11) begin
            err_cnt++; $display("FAIL stall_done got req%b v%b err%b cnt%0d exp req1 v0 err0 cnt11", req_next, m_valid, err_flag, word_cnt);
        end
        m_ready = 1'b1;
        cyc();
    endtask

    task automatic test_bad_codes();
        logic [31:0] codes [2];
        codes[0] = 32'hFFFF_FFFF;
        codes[1] = 32'd9;
        for (int j = 0; j < 2; j++) begin
            set_pkt(codes[j], 32'hC000_0000);
            pkt_load = 1'b1;
            cyc();
            pkt_load = 1'b0;
            vec_cnt++;
            if ({pkt_ready, m_valid, req_next, err_flag, end_flag} !== 5'b10110) begin
                err_cnt++; $display("FAIL bad_code%0d got %b exp 10110", j, {pkt_ready, m_valid, req_next, err_flag, end_flag});
            end
            cyc();
            vec_cnt++;
            if ({pkt_ready, m_valid, req_next, err_flag} !== 4'b1001) begin
                err_cnt++; $display("FAIL bad_after%0d got %b exp 1001", j, {pkt_ready, m_valid, req_next, err_flag});
            end
        end
        vec_cnt++;
        if (word_cnt !== 32'd11) begin
            err_cnt++; $display("FAIL bad_cnt got %0d exp 11", word_cnt);
        end
    endtask

    task automatic test_midload();
        do_reset();
        m_ready = 1'b1;
        set_pkt(32'd2, 32'hD000_0000);
        pkt_load = 1'b1;
        cyc();
        set_pkt(32'd1, 32'hEEEE_0000);
        m_ready = 1'b0;
        cyc();
        pkt_load = 1'b0;
        vec_cnt++;
        if ({err_flag, m_valid, m_last} !== 3'b110 || m_data !== 32'hD000_0000) begin
            err_cnt++; $display("FAIL midload_hold got e%b v%b l%b %h exp e1 v1 l0 d0000000", err_flag, m_valid, m_last, m_data);
        end
        m_ready = 1'b1;
        cyc();
        vec_cnt++;
        if ({m_valid, m_last} !== 2'b11 || m_data !== 32'hD000_0001) begin
            err_cnt++; $display("FAIL midload_w1 got v%b l%b %h exp v1 l1 d0000001", m_valid, m_last, m_data);
        end
        cyc();
        vec_cnt++;
        if ({req_next, m_valid} !== 2'b10 || word_cnt !== 32'd2) begin
            err_cnt++; $display("FAIL midload_done got req%b v%b cnt%0d exp req1 v0 cnt2", req_next, m_valid, word_cnt);
        end
        cyc();
        vec_cnt++;
        if ({m_valid, req_next, pkt_ready} !== 3'b001) begin
            err_cnt++; $display("FAIL midload_idle got %b exp 001", {m_valid, req_next, pkt_ready});
        end
    endtask

    task automatic test_end();
        set_pkt(32'd0, 32'h0);
        pkt_load = 1'b1;
        cyc();
        pkt_load = 1'b0;
        vec_cnt++;
        if ({end_flag, pkt_ready, m_valid, req_next} !== 4'b1000) begin
            err_cnt++; $display("FAIL end_enter got %b exp 1000", {end_flag, pkt_ready, m_valid, req_next});
        end
        set_pkt(32'd4, 32'hF000_0000);
        pkt_load = 1'b1;
        cyc();
        pkt_load = 1'b0;
        cyc();
        vec_cnt++;
        if ({end_flag, pkt_ready, m_valid, req_next, err_flag} !== 5'b10001 || word_cnt !== 32'd2) begin
            err_cnt++; $display("FAIL end_ignore got %b cnt%0d exp 10001 cnt2", {end_flag, pkt_ready, m_valid, req_next, err_flag}, word_cnt);
        end
        rst = 1'b1;
        #1;
        vec_cnt++;
        if ({end_flag, pkt_ready, err_flag} !== 3'b010) begin
            err_cnt++; $display("FAIL end_rst got %b exp 010", {end_flag, pkt_ready, err_flag});
        end
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_reset_midstream();
        m_ready = 1'b1;
        set_pkt(32'd4, 32'h1234_0000);
        pkt_load = 1'b1;
        cyc();
        pkt_load = 1'b0;
        cyc();
        vec_cnt++;
        if (m_data !== 32'h1234_0001 || word_cnt !== 32'd1) begin
            err_cnt++; $display("FAIL rstmid_pre got %h cnt%0d exp 12340001 cnt1", m_data, word_cnt);
        end
        cyc();
        rst = 1'b1;
        #1;
        vec_cnt++;
        if ({pkt_ready, m_valid, m_last, req_next, end_flag, err_flag} !== 6'b100000 || m_data !== 32'd0 || word_cnt !== 32'd0) begin
            err_cnt++; $display("FAIL rstmid_async got %b %h cnt%0d exp 100000 0 cnt0", {pkt_ready, m_valid, m_last, req_next, end_flag, err_flag}, m_data, word_cnt);
        end
        cyc();
        vec_cnt++;
        if ({req_next, m_valid} !== 2'b00) begin
            err_cnt++; $display("FAIL rstmid_noreq got %b exp 00", {req_next, m_valid});
        end
        rst = 1'b0;
        set_pkt(32'd1, 32'h5555_AAAA);
        pkt_load = 1'b1;
        cyc();
        pkt_load = 1'b0;
        vec_cnt++;
        if ({m_valid, m_last} !== 2'b11 || m_data !== 32'h5555_AAAA) begin
            err_cnt++; $display("FAIL rstmid_new got v%b l%b %h exp v1 l1 5555aaaa", m_valid, m_last, m_data);
        end
        cyc();
        vec_cnt++;
        if ({req_next, m_valid} !== 2'b10 || word_cnt !== 32'd1) begin
            err_cnt++; $display("FAIL rstmid_done got req%b v%b cnt%0d exp req1 v0 cnt1", req_next, m_valid, word_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_bad_codes();
        test_midload();
        test_end();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
